// File: rtl/alu_arm_pipe_if.sv
// Handshake and data bus between decode, the ALU execute stage and writeback.
interface alu_arm_pipe_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       op;
   logic [1:0]       mode;
   logic             set_flags;
   logic [WIDTH-1:0] da;
   logic [WIDTH-1:0] db;
   logic [WIDTH-1:0] dc;
   logic             shift_c;
   logic             flag_wr;
   logic [3:0]       flag_din;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic             wr_en;
   logic [3:0]       nzcv;

   modport slave (
      input  in_valid, op, mode, set_flags, da, db, dc, shift_c, flag_wr, flag_din, out_ready,
      output in_ready, out_valid, out, wr_en, nzcv
   );

   modport master (
      output in_valid, op, mode, set_flags, da, db, dc, shift_c, flag_wr, flag_din, out_ready,
      input  in_ready, out_valid, out, wr_en, nzcv
   );
endinterface

// File: rtl/alu_arm_pipe.sv
// Registered ARM data-processing ALU with NZCV register and an iterative
// shift-add MUL/MLA engine (one multiplier bit per cycle).
module alu_arm_pipe #(
   parameter int WIDTH  = 32,
   parameter int MUL_EN = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   alu_arm_pipe_if.slave  bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [0:0] {S_IDLE, S_MUL_BUSY} state_t;
   state_t r_state, w_state_nxt;

   logic [WIDTH-1:0] r_out, r_ma, r_mb, r_acc;
   logic             r_wr_en, r_out_valid, r_mset;
   logic [3:0]       r_nzcv;
   logic [CW-1:0]    r_cnt;

   logic             w_in_ready, w_accept, w_is_mul, w_cmp, w_mul_done;
   logic             w_arith, w_cin, w_c, w_v;
   logic [WIDTH-1:0] w_x, w_y, w_logic, w_res, w_mul_step;
   logic [WIDTH:0]   w_sum;

   assign w_in_ready = (r_state == S_IDLE) && (!r_out_valid || bus.out_ready);
   assign w_accept   = bus.in_valid && w_in_ready;
   assign w_is_mul   = (MUL_EN != 0) && ((bus.mode == 2'd1) || (bus.mode == 2'd2));
   assign w_cmp      = (bus.op[3:2] == 2'b01);
   assign w_mul_done = (r_state == S_MUL_BUSY) && (r_cnt == LAST);

   // Every arithmetic op is x + y + cin; subtraction uses the inverted operand
   // so the adder carry-out is directly the ARM NOT-borrow.
   always_comb begin
      w_x     = bus.da;
      w_y     = bus.db;
      w_cin   = 1'b0;
      w_arith = 1'b1;
      w_logic = '0;
      case (bus.op)
         4'b0000, 4'b0110: begin w_arith = 1'b0; w_logic = bus.da & bus.db; end
         4'b0001:          begin w_arith = 1'b0; w_logic = bus.da | bus.db; end
         4'b0010, 4'b0111: begin w_arith = 1'b0; w_logic = bus.da ^ bus.db; end
         4'b0011:          begin w_arith = 1'b0; w_logic = bus.da & ~bus.db; end
         4'b1000:          begin w_arith = 1'b0; w_logic = bus.db; end
         4'b1001:          begin w_arith = 1'b0; w_logic = ~bus.db; end
         4'b0100, 4'b1100: begin w_y = ~bus.db; w_cin = 1'b1; end
         4'b1011:          w_cin = r_nzcv[1];
         4'b1101:          begin w_y = ~bus.db; w_cin = r_nzcv[1]; end
         4'b1110:          begin w_x = bus.db; w_y = ~bus.da; w_cin = 1'b1; end
         4'b1111:          begin w_x = bus.db; w_y = ~bus.da; w_cin = r_nzcv[1]; end
         default: ;
      endcase
   end

   assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};
   assign w_res = w_arith ? w_sum[WIDTH-1:0] : w_logic;
   assign w_c   = w_arith ? w_sum[WIDTH] : bus.shift_c;
   assign w_v   = w_arith ? ((w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_res[WIDTH-1] != w_x[WIDTH-1]))
                          : r_nzcv[0];

   assign w_mul_step = r_acc + (r_mb[0] ? r_ma : '0);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:     if (w_accept && w_is_mul) w_state_nxt = S_MUL_BUSY;
         S_MUL_BUSY: if (r_cnt == LAST) w_state_nxt = S_IDLE;
         default:    w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ma <= '0; r_mb <= '0; r_acc <= '0; r_cnt <= '0; r_mset <= 1'b0;
      end else if (w_accept && w_is_mul) begin
         r_ma   <= bus.da;
         r_mb   <= bus.db;
         r_acc  <= (bus.mode == 2'd2) ? bus.dc : '0;
         r_cnt  <= '0;
         r_mset <= bus.set_flags;
      end else if (r_state == S_MUL_BUSY) begin
         r_acc <= w_mul_step;
         r_ma  <= r_ma << 1;
         r_mb  <= r_mb >> 1;
         r_cnt <= r_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out <= '0; r_wr_en <= 1'b0; r_out_valid <= 1'b0;
      end else if (w_accept && !w_is_mul) begin
         r_out <= w_res; r_wr_en <= !w_cmp; r_out_valid <= 1'b1;
      end else if (w_mul_done) begin
         r_out <= w_mul_step; r_wr_en <= 1'b1; r_out_valid <= 1'b1;
      end else if (bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   // An explicit flag load overrides any ALU flag update on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_nzcv <= 4'b0000;
      else if (bus.flag_wr)
         r_nzcv <= bus.flag_din;
      else if (w_accept && !w_is_mul && (bus.set_flags || w_cmp))
         r_nzcv <= {w_res[WIDTH-1], (w_res == '0), w_c, w_v};
      else if (w_mul_done && r_mset)
         r_nzcv[3:2] <= {w_mul_step[WIDTH-1], (w_mul_step == '0)};
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out       = r_out;
   assign bus.wr_en     = r_wr_en;
   assign bus.nzcv      = r_nzcv;
endmodule

// File: tb/tb_alu_arm_pipe.sv
// Randomised and directed checks of alu_arm_pipe against a behavioural
// model built from integer arithmetic and a result queue.
module tb_alu_arm_pipe;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_arm_pipe_if #(.WIDTH(W)) bus ();
   alu_arm_pipe #(.WIDTH(W), .MUL_EN(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct { logic [W-1:0] res; logic wr; } exp_t;
   exp_t          q[$];
   logic [3:0]    mflags;
   int            cd;
   logic [W-1:0]  mres;
   logic          mset;
   logic          last_acc;
   int            n_chk, n_err;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic reset_model();
      q.delete(); cd = 0; mflags = 4'b0000; mset = 1'b0; mres = '0;
   endtask

   // Check at the negedge, then advance the model across the next rising edge.
   task automatic step();
      logic       exp_rdy, acc, deliver, is_mul, logical, upd;
      logic [3:0] nf;
      longint unsigned a, b, c, u, r;
      longint sa, sb, sf;
      @(negedge clk);
      exp_rdy = (cd == 0) && (q.size() == 0 || bus.out_ready);
      chk("out_valid", bus.out_valid, q.size() != 0);
      chk("in_ready", bus.in_ready, exp_rdy);
      chk("nzcv", bus.nzcv, mflags);
      if (q.size() != 0 && bus.out_valid) begin
         chk("out", bus.out, q[0].res);
         chk("wr_en", bus.wr_en, q[0].wr);
      end
      acc = bus.in_valid && exp_rdy;
      last_acc = acc;
      deliver = (q.size() != 0) && bus.out_ready;
      nf = mflags;
      if (deliver) void'(q.pop_front());
      if (cd > 0) begin
         cd--;
         if (cd == 0) begin
            q.push_back('{mres, 1'b1});
            if (mset) nf[3:2] = {mres[W-1], mres == 0};
         end
      end
      if (acc) begin
         is_mul = (bus.mode == 2'd1) || (bus.mode == 2'd2);
         a = bus.da; b = bus.db; c = mflags[1];
         sa = $signed(bus.da); sb = $signed(bus.db);
         if (is_mul) begin
            u = a * b + ((bus.mode == 2'd2) ? longint'(bus.dc) : 0);
            mres = u[W-1:0]; mset = bus.set_flags; cd = W;
         end else begin
            logical = 1'b0; r = 0; u = 0; sf = 0;
            case (bus.op)
               4'd0, 4'd6: begin logical = 1'b1; r = a & b; end
               4'd1:       begin logical = 1'b1; r = a | b; end
               4'd2, 4'd7: begin logical = 1'b1; r = a ^ b; end
               4'd3:       begin logical = 1'b1; r = a & ~b; end
               4'd8:       begin logical = 1'b1; r = b; end
               4'd9:       begin logical = 1'b1; r = ~b; end
               4'd4, 4'd12: begin r = a - b; u = (a >= b); sf = sa - sb; end
               4'd5, 4'd10: begin r = a + b; u = r >> W; sf = sa + sb; end
               4'd11: begin r = a + b + c; u = r >> W; sf = sa + sb + longint'(c); end
               4'd13: begin r = a - b - (1 - c); u = (a >= b + (1 - c)); sf = sa - sb - longint'(1 - c); end
               4'd14: begin r = b - a; u = (b >= a); sf = sb - sa; end
               default: begin r = b - a - (1 - c); u = (b >= a + (1 - c)); sf = sb - sa - longint'(1 - c); end
            endcase
            q.push_back('{r[W-1:0], !(bus.op >= 4 && bus.op <= 7)});
            upd = bus.set_flags || (bus.op >= 4 && bus.op <= 7);
            if (upd) begin
               nf[3] = r[W-1];
               nf[2] = (r[W-1:0] == 0);
               nf[1] = logical ? bus.shift_c : u[0];
               if (!logical) nf[0] = (sf > 64'sh7FFF_FFFF) || (sf < -64'sh8000_0000);
            end
         end
      end
      if (bus.flag_wr) nf = bus.flag_din;
      mflags = nf;
      @(posedge clk); #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [1:0] mode, input logic s,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                        output int n);
      bus.op = op; bus.mode = mode; bus.set_flags = s;
      bus.da = a; bus.db = b; bus.dc = c; bus.shift_c = 1'b0;
      bus.in_valid = 1'b1;
      n = 0;
      do begin step(); n++; end while (!last_acc && n < 200);
      bus.in_valid = 1'b0;
      if (!last_acc) chk("accept_timeout", 0, 1);
   endtask

   task automatic drain();
      int k = 0;
      while ((q.size() != 0 || cd != 0) && k < 200) begin step(); k++; end
      if (k >= 200) chk("drain_timeout", 0, 1);
   endtask

   initial begin
      int n, k;
      n_chk = 0; n_err = 0; last_acc = 1'b0;
      reset_model();
      bus.in_valid = 0; bus.op = 0; bus.mode = 0; bus.set_flags = 0;
      bus.da = 0; bus.db = 0; bus.dc = 0; bus.shift_c = 0;
      bus.flag_wr = 0; bus.flag_din = 0; bus.out_ready = 1;
      #12;
      chk("rst_out", bus.out, 0);
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_wr", bus.wr_en, 0);
      chk("rst_nzcv", bus.nzcv, 0);
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", bus.in_ready, 1);

      issue(4'b1010, 2'd0, 1'b1, 32'h7FFF_FFFF, 32'h1, 32'h0, n);
      chk("t1_out", bus.out, 32'h8000_0000);
      chk("t1_wr", bus.wr_en, 1);
      chk("t1_nzcv", bus.nzcv, 4'b1001);

      issue(4'b0100, 2'd0, 1'b0, 32'd5, 32'd5, 32'h0, n);
      chk("t2_cmp_wr", bus.wr_en, 0);
      chk("t2_cmp_nzcv", bus.nzcv, 4'b0110);
      issue(4'b1101, 2'd0, 1'b0, 32'd10, 32'd3, 32'h0, n);
      chk("t2_sbc_issue", n, 1);
      chk("t2_sbc_out", bus.out, 32'd7);
      drain();

      issue(4'b0000, 2'd1, 1'b0, 32'h0000_FFFF, 32'h0001_0001, 32'h0, n);
      k = 0;
      while (!bus.out_valid && k < 100) begin step(); k++; end
      chk("t3_mul_lat", k, 32);
      chk("t3_mul_out", bus.out, 32'hFFFF_FFFF);
      drain();
      bus.flag_wr = 1'b1; bus.flag_din = 4'b1011; step(); bus.flag_wr = 1'b0;
      issue(4'b0000, 2'd2, 1'b1, 32'h0000_FFFF, 32'h0001_0001, 32'h1, n);
      k = 0;
      while (!bus.out_valid && k < 100) begin step(); k++; end
      chk("t3_mla_out", bus.out, 32'h0);
      chk("t3_mla_nzcv", bus.nzcv, 4'b0111);
      drain();

      bus.out_ready = 1'b0;
      issue(4'b1010, 2'd0, 1'b0, 32'd3, 32'd4, 32'h0, n);
      for (int i = 0; i < 3; i++) begin
         chk("t4_hold", bus.out, 32'd7);
         step();
      end
      bus.out_ready = 1'b1;
      step();
      chk("t4_drop", bus.out_valid, 0);

      issue(4'b0000, 2'd1, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, n);
      for (int i = 0; i < 9; i++) step();
      #2 rst_n = 1'b0;
      #1;
      chk("t5_out", bus.out, 0);
      chk("t5_valid", bus.out_valid, 0);
      chk("t5_nzcv", bus.nzcv, 0);
      reset_model();
      @(posedge clk); #1; rst_n = 1'b1;
      for (int i = 0; i < 40; i++) step();

      bus.flag_wr = 1'b1; bus.flag_din = 4'b0010;
      issue(4'b1100, 2'd0, 1'b1, 32'd0, 32'd1, 32'h0, n);
      bus.flag_wr = 1'b0;
      chk("t6_nzcv", bus.nzcv, 4'b0010);
      chk("t6_out", bus.out, 32'hFFFF_FFFF);
      drain();

      for (int i = 0; i < 1500; i++) begin
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.op        = 4'($urandom_range(0, 15));
         bus.mode      = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 2))
                       : (($urandom_range(0, 5) == 0) ? 2'd3 : 2'd0);
         bus.set_flags = 1'($urandom_range(0, 1));
         bus.da        = ($urandom_range(0, 7) == 0) ? 32'h7FFF_FFFF : $urandom;
         bus.db        = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
         bus.dc        = $urandom;
         bus.shift_c   = 1'($urandom_range(0, 1));
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.flag_wr   = ($urandom_range(0, 15) == 0);
         bus.flag_din  = 4'($urandom_range(0, 15));
         step();
      end
      bus.in_valid = 1'b0; bus.flag_wr = 1'b0; bus.out_ready = 1'b1;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/alu_arm_pipe.md
Name: alu_arm_pipe

Overview:
Parametrised, registered successor to the datapath ALU, and the execute-stage core for the pipelined CPU. It supports the full 16-opcode ARM data-processing set plus multi-cycle MUL/MLA via an iterative shift-add engine. It keeps an internal NZCV flag register with S-bit-controlled update, so ADC/SBC/RSC read carry from it. It sits between decode (valid/ready input) and writeback (valid/ready output).

Parameters:
WIDTH, 32, operand/result width in bits (>=8)
MUL_EN, 1, 1 = MUL/MLA supported; 0 = mode 1/2 treated as mode 0

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation request
in_ready  output  1  block can accept request this cycle
op  input  4  ARM data-proc opcode: AND 0000, OR 0001, EOR 0010, BIC 0011, CMP 0100, CMN 0101, TST 0110, TEQ 0111, MOV 1000, MVN 1001, ADD 1010, ADC 1011, SUB 1100, SBC 1101, RSB 1110, RSC 1111
mode  input  2  0 data-proc, 1 MUL, 2 MLA, 3 reserved (treated as 0)
set_flags  input  1  S bit; update NZCV from this op
da  input  WIDTH  operand A (Rn / Rm for multiply)
db  input  WIDTH  operand B (shifter output / Rs for multiply)
dc  input  WIDTH  MLA accumulate operand
shift_c  input  1  shifter carry-out, used as C for logical ops
flag_wr  input  1  external NZCV load (MSR)
flag_din  input  4  {N,Z,C,V} for flag_wr
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out  output  WIDTH  result
wr_en  output  1  result targets a register (0 for CMP/CMN/TST/TEQ)
nzcv  output  4  current flag register {N,Z,C,V}

Behaviour:
- Reset (async, rst_n=0): out=0, wr_en=0, out_valid=0, nzcv=0000, FSM=IDLE, multiply accumulators cleared. in_ready=1 once out of reset. Reset mid-multiply aborts it; no result is produced.
- Accept = in_valid & in_ready. in_ready = (state==IDLE) & (!out_valid | out_ready).
- FSM states: IDLE, MUL_BUSY.
  - IDLE, data-proc accept: result, wr_en and flags load at that edge. out_valid is high the next cycle (latency 1). Back-to-back issue at 1 op/cycle when out_ready=1.
  - IDLE, mode 1/2 accept: move to MUL_BUSY and latch da, db, dc.
  - MUL_BUSY: one multiplier bit per cycle, LSB first, for WIDTH cycles. On the final cycle, load out = low WIDTH bits of da*db (+dc for MLA), set out_valid, return to IDLE. A multiply accepted at edge k presents its result after edge k+WIDTH. in_ready=0 throughout.
- Output register: holds out/wr_en stable while out_valid & !out_ready. out_valid clears on out_ready when no new result loads in the same cycle.
- Arithmetic is WIDTH-bit modular. Carry is taken from the (WIDTH+1)-bit sum.
  - ADD/ADC/CMN: C = carry-out.
  - SUB/CMP/SBC/RSB/RSC: C = NOT borrow (ARM convention).
  - ADC = da+db+C. SBC = da-db-!C. RSC = db-da-!C. C is the flag register's C before update.
  - V = signed overflow of the actual operation, operand order respected for RSB/RSC.
- Flag update applies only when set_flags=1 at accept, or always for CMP/CMN/TST/TEQ.
  - N = out[WIDTH-1]; Z = (out==0).
  - Logical ops (AND, OR, EOR, BIC, TST, TEQ, MOV, MVN): C = shift_c, V unchanged.
  - MUL/MLA: N and Z updated at completion; C and V unchanged.
- Flags update at the same edge the result loads, so the next accepted op sees them.
- flag_wr: loads flag_din at the edge, in any state. Same edge as an ALU flag update: flag_wr wins.
- wr_en = 0 for opcodes 0100–0111 in mode 0, otherwise 1.

Test Plan:
1. ADDS (op 1010, S=1) da=0x7FFFFFFF, db=0x00000001 -> after 1 cycle out=0x80000000, wr_en=1, nzcv=1001.
2. CMP da=5, db=5, then SBC da=10, db=3 back-to-back -> CMP: wr_en=0, nzcv=0110. SBC (C=1): out=7, issued the cycle after CMP.
3. MUL da=0x0000FFFF, db=0x00010001 -> in_ready=0 for 32 cycles, out=0xFFFFFFFF exactly 32 edges after accept. MLA with the same operands, dc=1, S=1 -> out=0, Z=1, C/V unchanged.
4. Backpressure: ADD 3+4 with out_ready=0 for 3 cycles -> out=7 held stable, out_valid=1, in_ready=0. out_ready=1 -> out_valid drops next cycle unless a new op is accepted.
5. rst_n pulsed low at multiply cycle 10 -> all outputs go to reset values immediately, in_ready=1 after release, no out_valid ever for the aborted op.
6. flag_wr with flag_din=0010 at the same edge as SUBS 0-1 loads -> nzcv=0010, out=0xFFFFFFFF still delivered.
